// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arb_pkg : shared types and helpers for the dmem arbiter        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package dmem_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rsp_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_rsp_reg : per-port read response capture (rvalid/rdata)        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_rsp_reg
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              rvalid_d, rvalid_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_comb begin
        rvalid_d = cap;
        rdata_d  = cap ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_arbiter : CPU/debug arbiter for a single-port data memory      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int DEPTH        = 1024,
    parameter  int STARVE_LIMIT = 8,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          locked
);

    localparam logic [7:0] C_LIMIT = 8'(STARVE_LIMIT);

    logic [0:0] state_d, state_q;
    logic [7:0] wait_cnt_d, wait_cnt_q;
    logic       w_cpu_gnt, w_dbg_gnt;

    // In ARB the CPU wins unless debug has been denied for C_LIMIT cycles.
    always_comb begin
        w_dbg_gnt = 1'b0;
        w_cpu_gnt = 1'b0;
        if (state_q == ST_LOCKED) begin
            w_dbg_gnt = dbg_req;
        end else begin
            w_dbg_gnt = dbg_req && (!cpu_req || (wait_cnt_q == C_LIMIT));
            w_cpu_gnt = cpu_req && !w_dbg_gnt;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_ARB) begin
            if (w_dbg_gnt && dbg_lock) begin
                state_d = ST_LOCKED;
            end
        end else if (!dbg_lock) begin
            state_d = ST_ARB;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q == ST_LOCKED) || w_dbg_gnt || !dbg_req) begin
            wait_cnt_d = 8'd0;
        end else begin
            wait_cnt_d = sat_inc(wait_cnt_q, C_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    dmem_rsp_reg u_cpu_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (w_cpu_gnt && !cpu_we),
        .mem_rdata (mem_rdata),
        .rvalid    (cpu_rvalid),
        .rdata     (cpu_rdata)
    );

    dmem_rsp_reg u_dbg_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (w_dbg_gnt && !dbg_we),
        .mem_rdata (mem_rdata),
        .rvalid    (dbg_rvalid),
        .rdata     (dbg_rdata)
    );

    assign cpu_gnt   = w_cpu_gnt;
    assign dbg_gnt   = w_dbg_gnt;
    assign cpu_stall = cpu_req && !w_cpu_gnt;
    assign locked    = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: the CPU datapath (port `cpu_*`) and a debug/DMA loader (port `dbg_*`).
- Grants at most one access per cycle and drives the memory port.
- Returns read data registered, with a valid strobe.
- CPU has fixed priority, bounded by a starvation limit and a debug lock mode used for bulk load/dump.

Parameters:
- DEPTH, 1024, memory depth in words; ADDR_W = $clog2(DEPTH).
- STARVE_LIMIT, 8, consecutive denied debug cycles before debug wins over CPU; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_gnt  out  1  CPU access performed this cycle (combinational).
- cpu_stall  out  1  cpu_req && !cpu_gnt.
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_rdata  out  32  CPU read data (registered).
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write/read.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  32  debug write data.
- dbg_lock  in  1  request exclusive ownership while asserted.
- dbg_gnt  out  1  debug access performed this cycle (combinational).
- dbg_rvalid  out  1  debug read data valid (registered).
- dbg_rdata  out  32  debug read data (registered).
- mem_we  out  1  to memory write enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  32  to memory write data.
- mem_rdata  in  32  from memory, combinational read of mem_addr.
- locked  out  1  state == LOCKED.

Behaviour:
- Reset values:
  - state = ARB, wait_cnt = 0.
  - cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata all 0.
  - Grants are 0 when there is no request.
  - mem_* outputs are 0 when nothing is granted.
- Requester rule: hold req/we/addr/wdata stable until sampled gnt=1. One grant equals exactly one access.
- States:
  - ARB, default arbitration:
    - dbg_gnt = dbg_req && (!cpu_req || wait_cnt == STARVE_LIMIT).
    - cpu_gnt = cpu_req && !dbg_gnt.
  - LOCKED:
    - dbg_gnt = dbg_req.
    - cpu_gnt = 0, so a CPU request stalls.
- Transitions, evaluated at the clock edge:
  - ARB -> LOCKED when dbg_gnt && dbg_lock.
  - LOCKED -> ARB when !dbg_lock, whether or not dbg_req is asserted.
- Memory mux: the granted port drives mem_addr/mem_wdata, and mem_we = granted_we. A write commits in memory at the edge ending the grant cycle.
- Read latency: on a granted read, rdata <= mem_rdata at the edge and rvalid = 1 for exactly one cycle after the grant. rdata holds its value until the next read of that port. Writes never assert rvalid.
- wait_cnt (8 bit):
  - Cleared on dbg_gnt, when !dbg_req, and in LOCKED.
  - Otherwise incremented when dbg_req && !dbg_gnt, saturating at STARVE_LIMIT.
  - Guarantee: debug is granted within STARVE_LIMIT+1 cycles of continuous request.
- Simultaneous requests:
  - Never both grants high.
  - Below the limit the CPU wins.
  - At the limit debug wins exactly one access, then the counter restarts.
- Back-to-back grants to the same port are allowed every cycle, with rvalid pipelined one per cycle.
- Reset mid-operation: all state clears immediately (asynchronous), and any in-flight rvalid is dropped. Memory contents are unaffected.
- dbg_lock without dbg_req has no effect in ARB.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic {ARB, LOCKED} arb_state_t.
  - typedef struct mem_req_t {we, addr, wdata}, parameterised through ADDR_W via a localparam in the package defaulting to 10.
- Sub-module dmem_rsp_reg: one instance per port, holding the rvalid/rdata capture register with async reset.
- Arbitration and the FSM stay in the top level.

Test Plan:
- Reset, then cpu_req=1, cpu_we=0, addr=5, with mem[5]=0xDEADBEEF -> cpu_gnt=1 the same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; dbg outputs stay 0.
- cpu_req and dbg_req held continuously, STARVE_LIMIT=8 -> cpu_gnt for 8 cycles, dbg_gnt in cycle 9 only, then the CPU again, repeating every 9 cycles; never both grants high.
- dbg write burst with dbg_lock=1 to addresses 0..3 (data 0x10..0x13) while cpu_req=1 -> locked=1 after the first grant; cpu_stall=1 for 4 cycles; after dbg_lock drops, cpu_gnt=1 the next cycle; mem[0..3]=0x10..0x13.
- dbg_lock=1 with dbg_req=0 in ARB -> state stays ARB and cpu_gnt follows cpu_req.
- Reset asserted the cycle after a granted CPU read -> cpu_rvalid=0 and cpu_rdata=0 immediately; after release, state=ARB and wait_cnt=0 (first contention cycle grants the CPU).
- Back-to-back dbg reads of addresses 7, 8, 9 with no CPU request -> dbg_rvalid high for 3 consecutive cycles, with dbg_rdata = mem[7], mem[8], mem[9] in order.
